// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: memory-stage shared types (access FSM states) and the data-memory byte base.
package arm_mem_pkg;
  localparam logic [31:0] DATA_MEM_BASE = 32'd1024;
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_e;
endpackage

// File: rtl/mem_stage_sram_if.sv
// mem_stage_sram_if: pipeline-side bus; master drives MEM_R_EN/MEM_W_EN/ALU_Res/Val_Rm, slave returns Memory_Data/freeze.
interface mem_stage_sram_if;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] ALU_Res;
  logic [31:0] Val_Rm;
  logic [31:0] Memory_Data;
  logic        freeze;
  modport master (output MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, input Memory_Data, freeze);
  modport slave (input MEM_R_EN, MEM_W_EN, ALU_Res, Val_Rm, output Memory_Data, freeze);
endinterface

// File: rtl/sram_phase_counter.sv
// sram_phase_counter: modulo-N phase counter (clk, rst, clr_i clears, en_i advances, tc_o flags count N-1).
module sram_phase_counter #(
  parameter int N = 5,
  localparam int CW = $clog2(N)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tc_o  = cnt_q == CW'(N - 1);
    cnt_d = clr_i ? '0 : en_i ? (tc_o ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/mem_stage_sram.sv
// mem_stage_sram: splits a 32-bit load/store into two 16-bit SRAM phases with wait states (clk, rst, bus slave, SRAM_ADDR/SRAM_DQ/SRAM_WE_N).
module mem_stage_sram
  import arm_mem_pkg::*;
#(
  parameter int          WAIT_CYCLES = 5,
  parameter logic [31:0] ADDR_BASE   = DATA_MEM_BASE,
  parameter int          SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  mem_stage_sram_if.slave    bus,
  output logic [SRAM_AW-1:0] SRAM_ADDR,
  inout  wire  [15:0]        SRAM_DQ,
  output logic               SRAM_WE_N
);
  state_e state_q, state_d;
  logic wr_q, tc, req, active, oe;
  logic [31:0] md_q;
  logic [SRAM_AW-2:0] hw;
  sram_phase_counter #(.N(WAIT_CYCLES)) u_cnt (
    .clk(clk), .rst(rst), .clr_i(state_q == IDLE), .en_i(active), .tc_o(tc)
  );
  assign hw = (SRAM_AW - 1)'((bus.ALU_Res - ADDR_BASE) >> 2);
  assign oe = wr_q & active;
  assign SRAM_DQ = oe ? (state_q == HI ? bus.Val_Rm[31:16] : bus.Val_Rm[15:0]) : 16'bz;
  assign bus.Memory_Data = md_q;
  always_comb begin
    req        = bus.MEM_R_EN | bus.MEM_W_EN;
    active     = state_q == LO || state_q == HI;
    bus.freeze = (state_q == IDLE && req) || active;
    state_d    = state_q == IDLE ? (req ? LO : IDLE) :
                 state_q == LO   ? (tc ? HI : LO) :
                 state_q == HI   ? (tc ? DONE : HI) : IDLE;
    // WE_N rises on the last count so data is held past the strobe edge
    SRAM_WE_N  = !(oe && !tc);
    SRAM_ADDR  = state_q == LO ? {hw, 1'b0} : state_q == HI ? {hw, 1'b1} : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      md_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && req) wr_q <= bus.MEM_W_EN;
      if (!wr_q && tc && state_q == LO) md_q[15:0] <= SRAM_DQ;
      if (!wr_q && tc && state_q == HI) md_q[31:16] <= SRAM_DQ;
    end
  end
endmodule

// File: tb/tb_mem_stage_sram.sv
// tb_mem_stage_sram: directed stimulus with a cycle-offset reference model of the memory stage.
module tb_mem_stage_sram;
  localparam int W = 5;
  logic clk = 0, rst = 1, tb_rd = 0;
  logic [17:0] SRAM_ADDR;
  wire  [15:0] SRAM_DQ;
  logic SRAM_WE_N;
  logic [15:0] sram [0:255];
  int checks = 0, errors = 0;
  int fz_cnt = 0, we_cnt = 0;
  mem_stage_sram_if bus ();
  mem_stage_sram #(.WAIT_CYCLES(W)) dut (
    .clk(clk), .rst(rst), .bus(bus), .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ), .SRAM_WE_N(SRAM_WE_N)
  );
  always #5 clk = ~clk;
  assign SRAM_DQ = tb_rd ? sram[SRAM_ADDR[7:0]] : 16'bz;
  always @(posedge clk) if (!SRAM_WE_N) sram[SRAM_ADDR[7:0]] <= SRAM_DQ;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", n, a, e, $time);
    end
  endtask
  int k = -1;
  logic m_wr;
  logic [17:0] m_lo;
  logic [31:0] m_val, md_e = 0, word;
  logic [15:0] mem_m [0:255];
  logic lo_ph, hi_ph, e_fz, e_we;
  logic [17:0] e_ad;
  always @(negedge clk) begin
    if (rst) begin
      k = -1;
      md_e = 0;
    end else begin
      if (k < 0 && (bus.MEM_R_EN || bus.MEM_W_EN)) begin
        k = 0;
        m_wr = bus.MEM_W_EN;
        word = (bus.ALU_Res - 32'd1024) >> 2;
        m_lo = {word[16:0], 1'b0};
        m_val = bus.Val_Rm;
      end
      lo_ph = k >= 1 && k <= W;
      hi_ph = k > W && k <= 2 * W;
      e_fz = k >= 0 && k <= 2 * W;
      e_ad = lo_ph ? m_lo : hi_ph ? m_lo + 18'd1 : 18'd0;
      e_we = !(m_wr && (lo_ph || hi_ph) && k != W && k != 2 * W);
      chk("freeze", 32'(bus.freeze), 32'(e_fz));
      chk("addr", 32'(SRAM_ADDR), 32'(e_ad));
      chk("we_n", 32'(SRAM_WE_N), 32'(e_we));
      chk("mem_data", bus.Memory_Data, md_e);
      if (m_wr && lo_ph) chk("dq_lo", 32'(SRAM_DQ), 32'(m_val[15:0]));
      if (m_wr && hi_ph) chk("dq_hi", 32'(SRAM_DQ), 32'(m_val[31:16]));
      if (bus.freeze) fz_cnt++;
      if (!SRAM_WE_N) we_cnt++;
      if (k == W) begin
        if (m_wr) mem_m[m_lo[7:0]] = m_val[15:0];
        else md_e[15:0] = mem_m[m_lo[7:0]];
      end
      if (k == 2 * W) begin
        if (m_wr) mem_m[m_lo[7:0] + 8'd1] = m_val[31:16];
        else md_e[31:16] = mem_m[m_lo[7:0] + 8'd1];
      end
      k = (k < 0 || k == 2 * W + 1) ? -1 : k + 1;
    end
  end
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] v);
    bus.MEM_R_EN = r;
    bus.MEM_W_EN = w;
    bus.ALU_Res = a;
    bus.Val_Rm = v;
    tb_rd = r & !w;
    repeat (2 * W + 2) @(posedge clk);
    #1;
    bus.MEM_R_EN = 0;
    bus.MEM_W_EN = 0;
    tb_rd = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    bus.MEM_R_EN = 0;
    bus.MEM_W_EN = 0;
    bus.ALU_Res = 0;
    bus.Val_Rm = 0;
    idle(3);
    rst = 0;
    idle(10);
    chk("rst_mem_data", bus.Memory_Data, 32'h0);
    chk("rst_we_n", 32'(SRAM_WE_N), 32'h1);
    fz_cnt = 0; we_cnt = 0;
    access(0, 1, 32'd1028, 32'hDEADBEEF);
    chk("store_freeze_cycles", fz_cnt, 11);
    chk("store_we_low_cycles", we_cnt, 8);
    chk("store_sram2", 32'(sram[2]), 32'hBEEF);
    chk("store_sram3", 32'(sram[3]), 32'hDEAD);
    idle(2);
    fz_cnt = 0;
    access(1, 0, 32'd1028, 32'h0);
    chk("load_freeze_cycles", fz_cnt, 11);
    chk("load_data", bus.Memory_Data, 32'hDEADBEEF);
    idle(2);
    fz_cnt = 0;
    access(0, 1, 32'd1032, 32'hCAFEF00D);
    access(1, 0, 32'd1032, 32'h0);
    chk("b2b_freeze_cycles", fz_cnt, 22);
    chk("b2b_load_data", bus.Memory_Data, 32'hCAFEF00D);
    idle(2);
    bus.MEM_R_EN = 1;
    bus.ALU_Res = 32'd1028;
    tb_rd = 1;
    repeat (W + 2) @(posedge clk);
    #1;
    rst = 1;
    bus.MEM_R_EN = 0;
    tb_rd = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk("rst_mid_mem_data", bus.Memory_Data, 32'h0);
    chk("rst_mid_we_n", 32'(SRAM_WE_N), 32'h1);
    chk("rst_mid_freeze", 32'(bus.freeze), 32'h0);
    @(posedge clk);
    #1;
    access(1, 0, 32'd1028, 32'h0);
    chk("post_rst_load", bus.Memory_Data, 32'hDEADBEEF);
    idle(2);
    access(1, 1, 32'd1024, 32'h12345678);
    chk("both_en_sram0", 32'(sram[0]), 32'h5678);
    chk("both_en_sram1", 32'(sram[1]), 32'h1234);
    idle(1);
    access(1, 0, 32'd1024, 32'h0);
    chk("both_en_readback", bus.Memory_Data, 32'h12345678);
    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
